// File: rtl/daa_mac_sequencer_if.sv
// Operand handshake and datapath drive bundle used by daa_mac_sequencer.
interface daa_mac_sequencer_if #(
   parameter int WBITS = 8
);
   logic             op_valid;
   logic             op_ready;
   logic [3:0]       op_act;
   logic [WBITS-1:0] op_w;
   logic             dp_ena;
   logic             dp_clear;
   logic [3:0]       dp_inpe;
   logic [2:0]       dp_w;
   logic             dp_nep;
   logic [3:0]       dp_epcount;

   // Sequencer side: consumes operand pairs, drives the Booth/DAA datapath.
   modport master (
      input  op_valid, op_act, op_w,
      output op_ready, dp_ena, dp_clear, dp_inpe, dp_w, dp_nep, dp_epcount
   );

   // Environment side: operand source plus the datapath inputs.
   modport slave (
      output op_valid, op_act, op_w,
      input  op_ready, dp_ena, dp_clear, dp_inpe, dp_w, dp_nep, dp_epcount
   );
endinterface

// File: rtl/daa_mac_sequencer.sv
// Frame controller for the Booth/DAA accumulate datapath: accepts NPROD
// (activation, weight) pairs and issues one radix-4 Booth triplet per cycle,
// MSB digit first, followed by a fixed drain and a done pulse.
module daa_mac_sequencer #(
   parameter int WBITS     = 8,
   parameter int NPROD     = 9,
   parameter int DRAIN_CYC = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   daa_mac_sequencer_if.master bus,
   output logic                busy,
   output logic                done,
   output logic                aborted
);
   localparam int NDIG = WBITS / 2;
   localparam int KW   = $clog2(NDIG);
   localparam int DW   = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   // S_ABORT is the single clear cycle that follows a cancelled frame.
   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_LOAD, S_ISSUE, S_DRAIN, S_DONE, S_ABORT
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       p_q, p_d;
   logic [KW-1:0]    k_q, k_d;
   logic [DW-1:0]    drain_q, drain_d;
   logic [3:0]       act_q, act_d;
   logic [WBITS-1:0] w_q, w_d;

   logic       op_ready_q, op_ready_d;
   logic       ena_q, ena_d;
   logic       clear_q, clear_d;
   logic [3:0] inpe_q, inpe_d;
   logic [2:0] trip_q, trip_d;
   logic       nep_q, nep_d;
   logic [3:0] epcount_q, epcount_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       aborted_q, aborted_d;

   // Triplet {w[2k+1], w[2k], w[2k-1]} with w[-1] = 0, taken from {w, 0}.
   function automatic logic [2:0] booth_trip(input logic [WBITS-1:0] w,
                                             input logic [KW-1:0]    k);
      logic [WBITS:0] ext;
      ext = {w, 1'b0};
      return ext[2*int'(k) +: 3];
   endfunction

   // Next state, counters, operand latch, and outputs decoded from the next
   // state so that every output leaves a flop in step with the state.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d = state_q;
      p_d     = p_q;
      k_d     = k_q;
      drain_d = drain_q;
      act_d   = act_q;
      w_d     = w_q;

      unique case (state_q)
         S_IDLE:  if (start) state_d = S_CLEAR;
         S_CLEAR: state_d = S_LOAD;
         S_LOAD: begin
            if (bus.op_valid) begin
               act_d   = bus.op_act;
               w_d     = bus.op_w;
               k_d     = KW'(NDIG - 1);
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (k_q == '0) begin
               if (p_q == 4'(NPROD - 1)) begin
                  drain_d = DW'(DRAIN_CYC - 1);
                  state_d = S_DRAIN;
               end else begin
                  p_d     = p_q + 4'd1;
                  state_d = S_LOAD;
               end
            end else begin
               k_d = k_q - 1'b1;
            end
         end
         S_DRAIN: begin
            if (drain_q == '0) state_d = S_DONE;
            else               drain_d = drain_q - 1'b1;
         end
         S_DONE, S_ABORT: state_d = S_IDLE;
         default:         state_d = S_IDLE;
      endcase

      // Abort wins over operand acceptance and over every other transition;
      // DONE is already on its way out, so it is left alone.
      if (abort && (state_q inside {S_CLEAR, S_LOAD, S_ISSUE, S_DRAIN}))
         state_d = S_ABORT;

      // Leaving the frame wipes the bookkeeping so the next frame starts at slot 0.
      if (state_d inside {S_IDLE, S_ABORT}) begin
         p_d     = '0;
         k_d     = '0;
         drain_d = '0;
         act_d   = '0;
         w_d     = '0;
      end

      op_ready_d = (state_d == S_LOAD);
      ena_d      = (state_d inside {S_CLEAR, S_ISSUE, S_DRAIN, S_ABORT});
      clear_d    = (state_d inside {S_CLEAR, S_ABORT});
      inpe_d     = (state_d == S_ISSUE) ? act_d : '0;
      trip_d     = (state_d == S_ISSUE) ? booth_trip(w_d, k_d) : 3'b000;
      nep_d      = (state_d == S_ISSUE) && (k_d == '0);
      epcount_d  = p_d;
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
      aborted_d  = (state_d == S_ABORT);
   end

   // State, counters and registered outputs; rst clears all of them.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         p_q        <= '0;
         k_q        <= '0;
         drain_q    <= '0;
         act_q      <= '0;
         w_q        <= '0;
         op_ready_q <= 1'b0;
         ena_q      <= 1'b0;
         clear_q    <= 1'b0;
         inpe_q     <= '0;
         trip_q     <= '0;
         nep_q      <= 1'b0;
         epcount_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of the others.
         state_q    <= state_d;
         p_q        <= p_d;
         k_q        <= k_d;
         drain_q    <= drain_d;
         act_q      <= act_d;
         w_q        <= w_d;
         op_ready_q <= op_ready_d;
         ena_q      <= ena_d;
         clear_q    <= clear_d;
         inpe_q     <= inpe_d;
         trip_q     <= trip_d;
         nep_q      <= nep_d;
         epcount_q  <= epcount_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         aborted_q  <= aborted_d;
      end
   end

   assign bus.op_ready   = op_ready_q;
   assign bus.dp_ena     = ena_q;
   assign bus.dp_clear   = clear_q;
   assign bus.dp_inpe    = inpe_q;
   assign bus.dp_w       = trip_q;
   assign bus.dp_nep     = nep_q;
   assign bus.dp_epcount = epcount_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign aborted        = aborted_q;
endmodule
